// File: rtl/axi4lite_slave_mem.sv
// AXI4-Lite responder backed by a word-addressed RAM with byte strobes.
// Independent write and read FSMs, one outstanding transaction each, all outputs registered.
module axi4lite_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDR_WIDTH-1:0]     ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY
);
    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int LANES   = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (IDX_W + 2)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    wr_state_t             wr_state_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [LANES-1:0]      wstrb_q;

    rd_state_t             rd_state_q;
    logic                  arready_q, rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_hs, w_hs, ar_hs, wr_commit, wr_in_range;
    logic [ADDR_WIDTH-1:0] wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic [LANES-1:0]      wr_strb_d;

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID && wready_q;
    assign ar_hs = ARVALID && arready_q;

    // The completing handshake supplies its half live; the other half comes from the holding registers.
    assign wr_addr_d   = aw_hs ? AWADDR : awaddr_q;
    assign wr_data_d   = w_hs ? WDATA : wdata_q;
    assign wr_strb_d   = w_hs ? WSTRB : wstrb_q;
    assign wr_commit   = (aw_hs || wr_state_q == WR_HAVE_ADDR) && (w_hs || wr_state_q == WR_HAVE_DATA);
    assign wr_in_range = addr_in_range(wr_addr_d);

    // Storage is deliberately left out of reset so contents survive ARESET.
    always_ff @(posedge ACLK) begin
        if (wr_commit && wr_in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (wr_strb_d[b]) begin
                    mem[word_idx(wr_addr_d)][8*b +: 8] <= wr_data_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    if (wr_commit) begin
                        wr_state_q <= WR_RESP;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else if (aw_hs) begin
                        wr_state_q <= WR_HAVE_ADDR;
                        awready_q  <= 1'b0;
                        awaddr_q   <= AWADDR;
                    end else if (w_hs) begin
                        wr_state_q <= WR_HAVE_DATA;
                        wready_q   <= 1'b0;
                        wdata_q    <= WDATA;
                        wstrb_q    <= WSTRB;
                    end
                end
                WR_HAVE_ADDR: begin
                    if (wr_commit) begin
                        wr_state_q <= WR_RESP;
                        wready_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                WR_HAVE_DATA: begin
                    if (wr_commit) begin
                        wr_state_q <= WR_RESP;
                        awready_q  <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        wr_state_q <= WR_IDLE;
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    // A read sampling the RAM on a commit edge sees the old word (read-before-write).
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        rd_state_q <= RD_RESP;
                        arready_q  <= 1'b0;
                        rvalid_q   <= 1'b1;
                        if (addr_in_range(ARADDR)) begin
                            rdata_q <= mem[word_idx(ARADDR)];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_SLVERR;
                        end
                    end
                end
                RD_RESP: begin
                    if (RREADY) begin
                        rd_state_q <= RD_IDLE;
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;
endmodule

// File: tb/tb_axi4lite_slave_mem.sv
// Directed bench for axi4lite_slave_mem: a transaction-level memory model checked every
// cycle on the falling edge, plus literal expectations for each directed scenario.
module tb_axi4lite_slave_mem;
    logic        ACLK, ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    axi4lite_slave_mem dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mdl_mem [0:1023];
    bit          mdl_known [0:1023];
    bit          m_armed, m_have_aw, m_have_w, m_b_pend, m_r_pend, m_r_known;
    logic [31:0] m_aw_addr, m_w_data, m_r_data;
    logic [3:0]  m_w_strb;
    logic [1:0]  m_b_resp, m_r_resp;
    logic [9:0]  m_idx;
    bit          m_aw_hs, m_w_hs, m_ar_hs;

    initial begin
        for (int i = 0; i < 1024; i++) mdl_known[i] = 1'b0;
        m_armed = 0; m_have_aw = 0; m_have_w = 0; m_b_pend = 0; m_r_pend = 0; m_r_known = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET || !m_armed) begin
                check("idle_ctrl_zero", {23'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 32'd0);
                check("idle_rdata_zero", RDATA, 32'd0);
            end else begin
                check("awready", AWREADY, !(m_have_aw || m_b_pend));
                check("wready", WREADY, !(m_have_w || m_b_pend));
                check("arready", ARREADY, !m_r_pend);
                check("bvalid", BVALID, m_b_pend);
                if (m_b_pend) check("bresp", BRESP, m_b_resp);
                check("rvalid", RVALID, m_r_pend);
                if (m_r_pend) begin
                    check("rresp", RRESP, m_r_resp);
                    if (m_r_known) check("rdata", RDATA, m_r_data);
                end
            end
            if (ARESET) begin
                m_armed = 0; m_have_aw = 0; m_have_w = 0; m_b_pend = 0; m_r_pend = 0;
            end else begin
                // Predict what the coming rising edge does; inputs and outputs are stable until then.
                m_aw_hs = AWVALID && AWREADY;
                m_w_hs  = WVALID && WREADY;
                m_ar_hs = ARVALID && ARREADY;
                if (m_r_pend && RREADY) m_r_pend = 0;
                if (m_b_pend && BREADY) m_b_pend = 0;
                if (m_ar_hs) begin
                    m_r_pend = 1;
                    if (ARADDR < 32'h1000) begin
                        m_idx = ARADDR[11:2];
                        m_r_data = mdl_mem[m_idx];
                        m_r_known = mdl_known[m_idx];
                        m_r_resp = 2'b00;
                    end else begin
                        m_r_data = 32'd0;
                        m_r_known = 1;
                        m_r_resp = 2'b10;
                    end
                end
                if (m_aw_hs) begin m_have_aw = 1; m_aw_addr = AWADDR; end
                if (m_w_hs) begin m_have_w = 1; m_w_data = WDATA; m_w_strb = WSTRB; end
                if (m_have_aw && m_have_w) begin
                    if (m_aw_addr < 32'h1000) begin
                        m_idx = m_aw_addr[11:2];
                        for (int b = 0; b < 4; b++)
                            if (m_w_strb[b]) mdl_mem[m_idx][8*b +: 8] = m_w_data[8*b +: 8];
                        if (m_w_strb == 4'hF) mdl_known[m_idx] = 1;
                        m_b_resp = 2'b00;
                    end else begin
                        m_b_resp = 2'b10;
                    end
                    m_b_pend = 1; m_have_aw = 0; m_have_w = 0;
                end
                m_armed = 1;
            end
        end
    end

    // ---------------- stimulus helpers (entered and left at posedge + 1) ----------------
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay);
        bit aw_done = 0, w_done = 0, aw_fire, w_fire;
        for (int cyc = 0; cyc < 40 && !(aw_done && w_done); cyc++) begin
            if (cyc == aw_delay) begin AWVALID = 1; AWADDR = addr; end
            if (cyc == w_delay) begin WVALID = 1; WDATA = data; WSTRB = strb; end
            @(negedge ACLK);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (aw_fire) begin AWVALID = 0; aw_done = 1; end
            if (w_fire) begin WVALID = 0; w_done = 1; end
        end
        AWVALID = 0; WVALID = 0;
        check("write_handshakes", {30'd0, aw_done, w_done}, 32'd3);
    endtask

    task automatic get_b(output logic [1:0] resp, output int lat);
        resp = 2'b11; lat = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge ACLK);
            if (BVALID) begin resp = BRESP; lat = cyc; break; end
            @(posedge ACLK); #1;
        end
        if (lat >= 0) begin @(posedge ACLK); #1; end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output int lat);
        bit ok = 0, fire;
        data = 32'hxxxxxxxx; resp = 2'b11; lat = -1;
        ARVALID = 1; ARADDR = addr;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge ACLK);
            fire = ARREADY;
            @(posedge ACLK); #1;
            if (fire) begin ok = 1; break; end
        end
        ARVALID = 0;
        check("ar_accepted", {31'd0, ok}, 32'd1);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge ACLK);
            if (RVALID) begin data = RDATA; resp = RRESP; lat = cyc; break; end
            @(posedge ACLK); #1;
        end
        if (lat >= 0) begin @(posedge ACLK); #1; end
    endtask

    logic [1:0]  b_resp, r_resp;
    logic [31:0] r_data;
    int          b_lat, r_lat;

    task automatic expect_b(input string name, input logic [1:0] exp_resp);
        get_b(b_resp, b_lat);
        $display("B   %s: resp=%0b lat=%0d", name, b_resp, b_lat);
        check({name, "_blat"}, b_lat, 0);
        check({name, "_bresp"}, {30'd0, b_resp}, {30'd0, exp_resp});
    endtask

    task automatic expect_r(input string name, input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp);
        do_read(addr, r_data, r_resp, r_lat);
        $display("R   %s: addr=0x%08h data=0x%08h resp=%0b lat=%0d", name, addr, r_data, r_resp, r_lat);
        check({name, "_rlat"}, r_lat, 0);
        check({name, "_rdata"}, r_data, exp_data);
        check({name, "_rresp"}, {30'd0, r_resp}, {30'd0, exp_resp});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
        AWADDR = 0; WDATA = 0; WSTRB = 0; ARADDR = 0;
        repeat (3) @(posedge ACLK);
        #1;
        @(negedge ACLK);
        check("reset_readies", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        @(posedge ACLK); #1; ARESET = 0;
        @(negedge ACLK);
        check("release_before_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        @(negedge ACLK);
        check("release_after_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd7);
        @(posedge ACLK); #1;

        // Same-cycle AW/W then read back
        do_write(32'h600, 32'hDEADBEEF, 4'hF, 0, 0);
        expect_b("w600", 2'b00);
        expect_r("r600", 32'h600, 32'hDEADBEEF, 2'b00);

        // AR and write commit on the same edge: read returns the old word
        fork
            begin do_write(32'h600, 32'h0BADF00D, 4'hF, 0, 0); expect_b("w600_new", 2'b00); end
            expect_r("r600_rbw", 32'h600, 32'hDEADBEEF, 2'b00);
        join
        expect_r("r600_after", 32'h600, 32'h0BADF00D, 2'b00);

        // W first, AW three cycles later
        do_write(32'hFFC, 32'h12345678, 4'hF, 3, 0);
        expect_b("wffc", 2'b00);
        expect_r("rffc", 32'hFFC, 32'h12345678, 2'b00);

        // Byte strobes, including an all-zero strobe
        do_write(32'h700, 32'hFFFFFFFF, 4'hF, 0, 0);
        expect_b("w700_full", 2'b00);
        do_write(32'h700, 32'h00000000, 4'b0101, 0, 0);
        expect_b("w700_part", 2'b00);
        expect_r("r700_part", 32'h700, 32'hFF00FF00, 2'b00);
        do_write(32'h700, 32'h12345678, 4'b0000, 0, 0);
        expect_b("w700_nostrb", 2'b00);
        expect_r("r700_nostrb", 32'h700, 32'hFF00FF00, 2'b00);

        // Out-of-range access aliasing word 1 must not touch it
        do_write(32'h004, 32'h11223344, 4'hF, 0, 0);
        expect_b("w004", 2'b00);
        do_write(32'h1004, 32'hCAFEF00D, 4'hF, 0, 0);
        expect_b("w1004", 2'b10);
        expect_r("r1004", 32'h1004, 32'h00000000, 2'b10);
        expect_r("r004", 32'h004, 32'h11223344, 2'b00);

        // BREADY held low for five cycles
        BREADY = 0;
        do_write(32'h008, 32'hA5A5A5A5, 4'hF, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            check("bstall_bvalid_bresp", {29'd0, BVALID, BRESP}, 32'h4);
            check("bstall_readies", {30'd0, AWREADY, WREADY}, 32'd0);
            @(posedge ACLK); #1;
        end
        BREADY = 1;
        @(posedge ACLK); #1;
        AWVALID = 1; AWADDR = 32'h00C;
        @(negedge ACLK);
        check("aw_after_b", {31'd0, AWREADY}, 32'd1);
        @(posedge ACLK); #1; AWVALID = 0;
        WVALID = 1; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF;
        @(negedge ACLK);
        check("w_after_aw", {31'd0, WREADY}, 32'd1);
        @(posedge ACLK); #1; WVALID = 0;
        expect_b("w00c", 2'b00);
        expect_r("r00c", 32'h00C, 32'h5A5A5A5A, 2'b00);
        expect_r("r008", 32'h008, 32'hA5A5A5A5, 2'b00);

        // Reset after AW but before W discards the half transaction
        do_write(32'h800, 32'h600DCAFE, 4'hF, 0, 0);
        expect_b("w800", 2'b00);
        AWVALID = 1; AWADDR = 32'h800;
        @(negedge ACLK);
        check("aw_before_reset", {31'd0, AWREADY}, 32'd1);
        @(posedge ACLK); #1; AWVALID = 0;
        #1 ARESET = 1;
        @(negedge ACLK);
        check("midreset_ctrl", {23'd0, AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP}, 32'd0);
        check("midreset_rdata", RDATA, 32'd0);
        WVALID = 1; WDATA = 32'hBAD0BAD0; WSTRB = 4'hF;
        repeat (2) @(posedge ACLK);
        #1; ARESET = 0; WVALID = 0;
        @(negedge ACLK);
        check("rerelease_before_edge", {29'd0, AWREADY, WREADY, ARREADY}, 32'd0);
        @(negedge ACLK);
        check("rerelease_after_edge", {29'd0, AWREADY, WREADY, ARREADY, BVALID}, 32'hE);
        @(posedge ACLK); #1;
        expect_r("r800_kept", 32'h800, 32'h600DCAFE, 2'b00);
        do_write(32'h900, 32'h900D900D, 4'hF, 0, 0);
        expect_b("w900", 2'b00);
        expect_r("r800_again", 32'h800, 32'h600DCAFE, 2'b00);
        expect_r("r900", 32'h900, 32'h900D900D, 2'b00);

        repeat (3) @(posedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4lite_slave_mem.md
AXI4LITE_SLAVE_MEM -- requirements
Module: axi4lite_slave_mem

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 32, AWADDR/ARADDR width.
- DATA_WIDTH, 32, WDATA/RDATA width (only 32 supported).
- MEM_WORDS, 1024, 32-bit words of storage; the byte range is 0x000-0xFFF.

REQ-002 Ports, one per line: name, direction, width, meaning.
- ACLK, in, 1, single clock; all logic on the rising edge.
- ARESET, in, 1, asynchronous, active-high reset.
- AWADDR, in, ADDR_WIDTH, write address.
- AWVALID, in, 1, write address valid.
- AWREADY, out, 1, write address ready.
- WDATA, in, 32, write data.
- WSTRB, in, 4, byte-lane strobes.
- WVALID, in, 1, write data valid.
- WREADY, out, 1, write data ready.
- BRESP, out, 2, write response: 00 = OKAY, 10 = SLVERR.
- BVALID, out, 1, write response valid.
- BREADY, in, 1, write response ready.
- ARADDR, in, ADDR_WIDTH, read address.
- ARVALID, in, 1, read address valid.
- ARREADY, out, 1, read address ready.
- RDATA, out, 32, read data.
- RRESP, out, 2, read response.
- RVALID, out, 1, read data valid.
- RREADY, in, 1, read data ready.

REQ-003 The block is the AXI4-Lite responder for the team testbench's initiator. A handshake occurs on a rising edge where VALID and READY are both high.

Function
REQ-004 The write and read paths are independent FSMs; each path has at most one outstanding transaction.

REQ-005 Write FSM states and transitions:
- WR_IDLE: AWREADY = 1, WREADY = 1.
- WR_HAVE_ADDR: AWREADY = 0, WREADY = 1.
- WR_HAVE_DATA: AWREADY = 1, WREADY = 0.
- WR_RESP: AWREADY = 0, WREADY = 0, BVALID = 1.
- From WR_IDLE: go to WR_HAVE_ADDR on an AW handshake only, WR_HAVE_DATA on a W handshake only, WR_RESP on both in the same cycle.
- From WR_HAVE_ADDR or WR_HAVE_DATA: go to WR_RESP on the missing handshake.
- From WR_RESP: go to WR_IDLE on BREADY.

REQ-006 The write commits to memory on the edge that completes the AW/W pair. BVALID rises on that same edge, so it is visible the cycle after the last handshake.

REQ-007 Address decode:
- Word index = AWADDR[11:2]; AWADDR[1:0] are ignored.
- If AWADDR >= 0x1000: no memory update, BRESP = SLVERR.
- Otherwise BRESP = OKAY.

REQ-008 Only bytes whose WSTRB bit is 1 are updated. WSTRB = 0000 gives OKAY with no change.

REQ-009 BVALID and BRESP hold stable until BREADY. BREADY sampled while BVALID is low has no effect.

REQ-010 Read FSM states and transitions:
- RD_IDLE: ARREADY = 1.
- RD_RESP: ARREADY = 0, RVALID = 1.
- An AR handshake in RD_IDLE registers RDATA/RRESP and moves to RD_RESP. RVALID is visible the cycle after the handshake (latency 1).
- RD_RESP goes to RD_IDLE on RREADY. RDATA and RRESP hold stable until then.

REQ-011 Read decode:
- ARADDR >= 0x1000 gives RDATA = 0 and RRESP = SLVERR.
- Otherwise RRESP = OKAY and RDATA = mem[ARADDR[11:2]].

REQ-012 If an AR handshake and a write commit to the same word fall on the same edge, the read returns the pre-write data (read-before-write).

REQ-013 A write commit followed by an AR handshake one or more cycles later returns the new data.

REQ-014 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-015 While ARESET = 1, all outputs are 0: AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA. Both FSMs are in IDLE and held address/data are cleared.

REQ-016 On the first rising edge after ARESET falls, AWREADY, WREADY and ARREADY become 1.

REQ-017 Memory contents are not reset; they are preserved across ARESET.

REQ-018 ARESET asserted mid-transaction aborts it:
- Any pending BVALID/RVALID drops immediately.
- A half-captured AW or W is discarded with no memory update.

Verification
REQ-019 Directed scenarios the bench shall cover:
- Write AWADDR = 0x600, WDATA = 0xDEADBEEF, WSTRB = 1111, AW and W in the same cycle, BREADY = 1 -> BVALID one cycle later with BRESP = 00. Then read 0x600 -> RVALID one cycle after AR, RDATA = 0xDEADBEEF, RRESP = 00.
- W at cycle N (0x12345678), AW (0xFFC) at cycle N+3 -> AWREADY stays 1 and WREADY = 0 in between; BVALID at N+4. Read 0xFFC -> 0x12345678.
- Word 0x700 = 0xFFFFFFFF, then write 0x00000000 with WSTRB = 0101 -> read 0x700 returns 0xFF00FF00.
- Write and read at AWADDR/ARADDR = 0x1004 -> BRESP = 10, RRESP = 10, RDATA = 0; memory unchanged.
- BREADY held low for 5 cycles -> BVALID, BRESP stable and AWREADY = WREADY = 0 throughout; a new AW is accepted the cycle after BREADY.
- AW accepted, then ARESET pulsed before W -> all outputs 0 during reset, READYs = 1 one edge after release, target word unchanged.
